// File: rtl/coeff_loader_if.sv
// Host-link and cell-bank signal bundle for the coefficient loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever drives the byte stream and observes the cell bus (host or bench).
interface coeff_loader_if #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic [DEPTH-1:0] cell_ce;
   logic             cell_we;
   logic [WIDTH-1:0] cell_d;
   logic             busy;
   logic             done;
   logic             error;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, cell_ce, cell_we, cell_d, busy, done, error
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, cell_ce, cell_we, cell_d, busy, done, error
   );
endinterface

// File: rtl/coeff_loader.sv
// coeff_loader: fills the decision-tree coefficient cells from a framed,
// MSB-first byte stream (header N, then N words of WIDTH/8 bytes).
// Optional feature macro COEFF_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and a CHECK state; without it the frame ends after the
// last payload byte.
module coeff_loader #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   coeff_loader_if.slave bus
);

   localparam int BYTES = WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
`ifdef COEFF_LOADER_CHECKSUM_EN
      , CHECK = 2'd3
`endif
   } state_t;

   state_t           r_state,   w_state;
   logic [7:0]       r_count,   w_count;
   logic [7:0]       r_addr,    w_addr;
   logic [BCW-1:0]   r_byteCnt, w_byteCnt;
   logic [WIDTH-1:0] r_word,    w_word;
   logic [DEPTH-1:0] r_ce,      w_ce;
   logic             r_we,      w_we;
   logic [WIDTH-1:0] r_d,       w_d;
   logic             r_busy,    w_busy;
   logic             r_done,    w_done;
   logic             r_error,   w_error;
`ifdef COEFF_LOADER_CHECKSUM_EN
   logic [7:0]       r_csum,    w_csum;
`endif

   logic             w_accept;
   logic [WIDTH+7:0] w_ext;
   logic [WIDTH-1:0] w_asm;
   logic             w_badHeader;

   // The loader can take a byte in every state except IDLE.
   assign bus.in_ready = (r_state != IDLE);
   assign w_accept     = bus.in_valid && (r_state != IDLE);

   // Shift the new byte in below the partial word; the top byte falls off.
   assign w_ext = {r_word, bus.in_data};
   assign w_asm = w_ext[WIDTH-1:0];

   // A header of zero words or more words than cells cannot be honoured.
   assign w_badHeader = (bus.in_data == 8'd0) || ({24'd0, bus.in_data} > 32'(DEPTH));

   assign bus.cell_ce = r_ce;
   assign bus.cell_we = r_we;
   assign bus.cell_d  = r_d;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.error   = r_error;

   // State register and all registered outputs; reset drops any pending strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_addr    <= '0;
         r_byteCnt <= '0;
         r_word    <= '0;
         r_ce      <= '0;
         r_we      <= 1'b0;
         r_d       <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
         r_csum    <= '0;
`endif
      end else begin
         r_state   <= w_state;
         r_count   <= w_count;
         r_addr    <= w_addr;
         r_byteCnt <= w_byteCnt;
         r_word    <= w_word;
         r_ce      <= w_ce;
         r_we      <= w_we;
         r_d       <= w_d;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_error   <= w_error;
`ifdef COEFF_LOADER_CHECKSUM_EN
         r_csum    <= w_csum;
`endif
      end
   end

   // Frame sequencing: next state plus the values the output registers take.
   // Strobes and done are single-cycle, so they default low every cycle.
   always_comb begin
      w_state   = r_state;
      w_count   = r_count;
      w_addr    = r_addr;
      w_byteCnt = r_byteCnt;
      w_word    = r_word;
      w_ce      = '0;
      w_we      = 1'b0;
      w_d       = r_d;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_error   = r_error;
`ifdef COEFF_LOADER_CHECKSUM_EN
      w_csum    = r_csum;
`endif

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state   = HEADER;
               w_error   = 1'b0;
               w_addr    = '0;
               w_byteCnt = '0;
               w_busy    = 1'b1;
`ifdef COEFF_LOADER_CHECKSUM_EN
               w_csum    = '0;
`endif
            end
         end

         HEADER: begin
            if (w_accept) begin
               if (w_badHeader) begin
                  w_state = IDLE;
                  w_error = 1'b1;
                  w_busy  = 1'b0;
               end else begin
                  w_count = bus.in_data;
                  w_state = DATA;
               end
            end
         end

         DATA: begin
            if (w_accept) begin
               w_word = w_asm;
`ifdef COEFF_LOADER_CHECKSUM_EN
               w_csum = r_csum ^ bus.in_data;
`endif
               if (r_byteCnt == BCW'(BYTES - 1)) begin
                  w_byteCnt = '0;
                  w_ce      = DEPTH'(1) << r_addr;
                  w_we      = 1'b1;
                  w_d       = w_asm;
                  w_addr    = r_addr + 8'd1;
                  if (r_addr == r_count - 8'd1) begin
`ifdef COEFF_LOADER_CHECKSUM_EN
                     w_state = CHECK;
`else
                     w_state = IDLE;
                     w_done  = 1'b1;
                     w_busy  = 1'b0;
`endif
                  end
               end else begin
                  w_byteCnt = r_byteCnt + BCW'(1);
               end
            end
         end

`ifdef COEFF_LOADER_CHECKSUM_EN
         CHECK: begin
            if (w_accept) begin
               w_state = IDLE;
               w_busy  = 1'b0;
               if (bus.in_data == r_csum) begin
                  w_done = 1'b1;
               end else begin
                  w_error = 1'b1;
               end
            end
         end
`endif

         default: begin
            w_state = IDLE;
         end
      endcase
   end

endmodule
